// File: rtl/sram_byte_streamer_pkg.sv
// Shared definitions for the SRAM byte streamer: FSM encoding and default sizes.
package tart_stream_pkg;
  localparam int DEF_ABITS = 11;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } stream_state_t;
endpackage

// File: rtl/sram_byte_streamer_if.sv
// Command, SRAM byte-port and byte-stream signals of the streamer.
// master = streamer side, slave = surrounding logic (SRAM + SPI transmit path).
interface sram_byte_streamer_if
  import tart_stream_pkg::*;
#(parameter int ABITS = DEF_ABITS);
  logic             start_i;
  logic             abort_i;
  logic [ABITS-1:0] base_i;
  logic [ABITS:0]   count_i;
  logic             busy_o;
  logic             done_o;
  logic             sram_en_o;
  logic [ABITS-1:0] sram_adr_o;
  logic [7:0]       sram_dat_i;
  logic             valid_o;
  logic [7:0]       data_o;
  logic             last_o;
  logic             ready_i;

  modport master (
    input  start_i, abort_i, base_i, count_i, sram_dat_i, ready_i,
    output busy_o, done_o, sram_en_o, sram_adr_o, valid_o, data_o, last_o
  );

  modport slave (
    output start_i, abort_i, base_i, count_i, sram_dat_i, ready_i,
    input  busy_o, done_o, sram_en_o, sram_adr_o, valid_o, data_o, last_o
  );
endinterface

// File: rtl/sram_byte_streamer_fifo.sv
// First-word-fall-through byte FIFO with a per-entry last flag, flush and
// occupancy output. Head outputs read as zero while empty.
module sram_stream_fifo
  import tart_stream_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic [7:0]  push_dat_i,
  input  logic        push_last_i,
  input  logic        pop_i,
  output logic        valid_o,
  output logic [7:0]  data_o,
  output logic        last_o,
  output logic [AW:0] occ_o
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (occ != '0);
  assign do_push = push_i && ((occ != FULL) || do_pop);

  // Pointer and occupancy bookkeeping; flush empties the queue at once.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage needs no reset: outputs are gated by occupancy.
  always_ff @(posedge clock_i) begin
    if (do_push && !flush_i) mem[wr_ptr] <= {push_last_i, push_dat_i};
  end

  assign valid_o = (occ != '0);
  assign data_o  = valid_o ? mem[rd_ptr][7:0] : 8'h00;
  assign last_o  = valid_o && mem[rd_ptr][8];
  assign occ_o   = occ;
endmodule

// File: rtl/sram_byte_streamer.sv
// Streams a run of bytes from the SRAM byte port as a valid/ready byte stream.
// Reads are issued only when the FIFO is guaranteed room for every read in
// flight, so the one-cycle SRAM latency never overruns the FIFO.
module sram_byte_streamer
  import tart_stream_pkg::*;
#(
  parameter int ABITS = DEF_ABITS,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic                clock_i,
  input logic                reset_i,
  sram_byte_streamer_if.master bus
);
  localparam int             OW      = $clog2(DEPTH) + 1;
  localparam logic [ABITS:0] CNT_ONE = (ABITS+1)'(1);
  localparam logic [OW:0]    CAP     = (OW+1)'(DEPTH);

  stream_state_t    state_q, state_d;
  logic [ABITS-1:0] adr_q;
  logic [ABITS:0]   left_q;
  logic             en_q, last_en_q, pend_q, last_pend_q, done_q;
  logic             issue, load, flush, done_d, pop, credit_ok, issue_last;
  logic [OW-1:0]    occ;
  logic [OW:0]      inflight;
  logic             fifo_valid, fifo_last;
  logic [7:0]       fifo_data;

  // Slots claimed = bytes queued + read being presented + read landing now.
  assign pop        = fifo_valid && bus.ready_i;
  assign inflight   = {1'b0, occ} + {{OW{1'b0}}, en_q} + {{OW{1'b0}}, pend_q};
  assign credit_ok  = inflight < (CAP + {{OW{1'b0}}, pop});
  assign issue_last = load ? (bus.count_i == CNT_ONE) : (left_q == CNT_ONE);

  // State register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state, read issue, flush and completion decisions.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    load    = 1'b0;
    flush   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          if (bus.count_i == '0) begin
            done_d = 1'b1;
          end else begin
            load    = 1'b1;
            issue   = 1'b1;
            state_d = (bus.count_i == CNT_ONE) ? ST_DRAIN : ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (bus.abort_i) begin
          flush   = 1'b1;
          state_d = ST_IDLE;
        end else if (credit_ok) begin
          issue = 1'b1;
          if (left_q == CNT_ONE) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.abort_i) begin
          flush   = 1'b1;
          state_d = ST_IDLE;
        end else if (pop && fifo_last) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read strobe/address, remaining count and the read-latency pipeline.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      adr_q       <= '0;
      left_q      <= '0;
      en_q        <= 1'b0;
      last_en_q   <= 1'b0;
      pend_q      <= 1'b0;
      last_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      en_q        <= issue;
      last_en_q   <= issue && issue_last;
      pend_q      <= en_q && !flush;
      last_pend_q <= last_en_q && !flush;
      done_q      <= done_d;
      if (load) begin
        adr_q  <= bus.base_i;
        left_q <= bus.count_i - CNT_ONE;
      end else if (issue) begin
        adr_q  <= adr_q + 1'b1;
        left_q <= left_q - CNT_ONE;
      end
    end
  end

  sram_stream_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .flush_i     (flush),
    .push_i      (pend_q),
    .push_dat_i  (bus.sram_dat_i),
    .push_last_i (last_pend_q),
    .pop_i       (pop),
    .valid_o     (fifo_valid),
    .data_o      (fifo_data),
    .last_o      (fifo_last),
    .occ_o       (occ)
  );

  assign bus.busy_o     = (state_q != ST_IDLE);
  assign bus.done_o     = done_q;
  assign bus.sram_en_o  = en_q;
  assign bus.sram_adr_o = adr_q;
  assign bus.valid_o    = fifo_valid;
  assign bus.data_o     = fifo_data;
  assign bus.last_o     = fifo_last;
endmodule
